// File: rtl/mem_seq_master.sv
// Host command sequencer for the 16-byte DFF memory bus, with registered bus outputs.
// Define MEM_BIST_EN to build in the two-pass march test engine.
module mem_seq_master #(
    parameter int                ADDR_W = 4,
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] SEED   = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ce_n,
    output logic              mem_lr_n,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic [ADDR_W-1:0] bist_fail_addr
);

`ifdef MEM_BIST_EN
    typedef enum logic [2:0] {IDLE, WR, RD, RDW, B_WR, B_RD, B_RDW, B_DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;
`endif

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              ce_n_nx;
    logic              lr_n_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic              rsp_nx;

`ifdef MEM_BIST_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] bcnt, bcnt_nx;
    logic              phase, phase_nx;
    logic              pass_nx;
    logic [ADDR_W-1:0] fail_nx;

    // Pass 0 writes SEED^a, pass 1 writes its complement.
    function automatic logic [DATA_W-1:0] pattern(input logic ph, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        d = SEED ^ DATA_W'(a);
        return ph ? ~d : d;
    endfunction

    assign cmd_ready = (state == IDLE) && !bist_start;
    assign bist_busy = (state == B_WR) || (state == B_RD) || (state == B_RDW);
    assign bist_done = (state == B_DONE);
`else
    logic unused_bist;

    assign cmd_ready      = (state == IDLE);
    assign bist_busy      = 1'b0;
    assign bist_done      = 1'b0;
    assign bist_pass      = 1'b0;
    assign bist_fail_addr = '0;
    assign unused_bist    = ^{bist_start, SEED, 1'(DEPTH)};
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx = state;
        addr_nx  = '0;
        ce_n_nx  = 1'b1;
        lr_n_nx  = 1'b1;
        wdata_nx = '0;
        rsp_nx   = 1'b0;
`ifdef MEM_BIST_EN
        bcnt_nx  = bcnt;
        phase_nx = phase;
        pass_nx  = bist_pass;
        fail_nx  = bist_fail_addr;
`endif
        case (state)
            IDLE: begin
`ifdef MEM_BIST_EN
                if (bist_start) begin
                    state_nx = B_WR;
                    lr_n_nx  = 1'b0;
                    wdata_nx = pattern(1'b0, '0);
                    bcnt_nx  = '0;
                    phase_nx = 1'b0;
                    pass_nx  = 1'b0;
                    fail_nx  = '0;
                end else
`endif
                if (cmd_valid) begin
                    addr_nx = cmd_addr;
                    if (cmd_write) begin
                        state_nx = WR;
                        lr_n_nx  = 1'b0;
                        wdata_nx = cmd_wdata;
                    end else begin
                        state_nx = RD;
                        ce_n_nx  = 1'b0;
                    end
                end
            end
            WR:  state_nx = IDLE;
            RD:  state_nx = RDW;
            RDW: begin
                state_nx = IDLE;
                rsp_nx   = 1'b1;
            end
`ifdef MEM_BIST_EN
            B_WR: begin
                if (bcnt == LAST) begin
                    state_nx = B_RD;
                    ce_n_nx  = 1'b0;
                    bcnt_nx  = '0;
                end else begin
                    bcnt_nx  = bcnt + 1'b1;
                    lr_n_nx  = 1'b0;
                    addr_nx  = bcnt_nx;
                    wdata_nx = pattern(phase, bcnt_nx);
                end
            end
            B_RD: state_nx = B_RDW;
            B_RDW: begin
                // mem_rdata holds the word read at the previous edge.
                if (mem_rdata != pattern(phase, bcnt)) begin
                    state_nx = B_DONE;
                    fail_nx  = bcnt;
                    pass_nx  = 1'b0;
                end else if (bcnt == LAST) begin
                    if (!phase) begin
                        state_nx = B_WR;
                        phase_nx = 1'b1;
                        bcnt_nx  = '0;
                        lr_n_nx  = 1'b0;
                        wdata_nx = pattern(1'b1, '0);
                    end else begin
                        state_nx = B_DONE;
                        pass_nx  = 1'b1;
                    end
                end else begin
                    state_nx = B_RD;
                    bcnt_nx  = bcnt + 1'b1;
                    ce_n_nx  = 1'b0;
                    addr_nx  = bcnt_nx;
                end
            end
            B_DONE: state_nx = IDLE;
`endif
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            mem_addr       <= '0;
            mem_ce_n       <= 1'b1;
            mem_lr_n       <= 1'b1;
            mem_wdata      <= '0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
`ifdef MEM_BIST_EN
            bcnt           <= '0;
            phase          <= 1'b0;
            bist_pass      <= 1'b0;
            bist_fail_addr <= '0;
`endif
        end else begin
            state     <= state_nx;
            mem_addr  <= addr_nx;
            mem_ce_n  <= ce_n_nx;
            mem_lr_n  <= lr_n_nx;
            mem_wdata <= wdata_nx;
            rsp_valid <= rsp_nx;
            if (rsp_nx)
                rsp_rdata <= mem_rdata;
`ifdef MEM_BIST_EN
            bcnt           <= bcnt_nx;
            phase          <= phase_nx;
            bist_pass      <= pass_nx;
            bist_fail_addr <= fail_nx;
`endif
        end
    end

endmodule

// File: tb/tb_mem_seq_master.sv
// Scoreboard bench for mem_seq_master: behavioural DFF memory, reference array and
// response monitor; BIST scenarios are exercised when MEM_BIST_EN is defined.
module tb_mem_seq_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [3:0] mem_addr;
    logic       mem_ce_n, mem_lr_n;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       bist_start, bist_busy, bist_done, bist_pass;
    logic [3:0] bist_fail_addr;

    mem_seq_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_lr_n(mem_lr_n),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .bist_start(bist_start), .bist_busy(bist_busy), .bist_done(bist_done),
        .bist_pass(bist_pass), .bist_fail_addr(bist_fail_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory; fault_en makes bit 2 of address 9 stuck at 0.
    logic [7:0] mem [16];
    logic       fault_en = 1'b0;
    always @(posedge clk) begin
        if (!mem_lr_n)
            mem[mem_addr] <= (fault_en && mem_addr == 4'd9) ? (mem_wdata & 8'hFB) : mem_wdata;
        else if (!mem_ce_n)
            mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic [7:0] ref_mem [16];
    exp_t       sb[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         bist_mode = 1'b0;
    bit         prev_act  = 1'b0;
    bit         bus_act;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor and bus protocol watcher.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.data);
                    check("rsp_cycle", cyc, mon_e.due);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                check("rsp_missing", rsp_valid, 1);
                void'(sb.pop_front());
            end
            bus_act = !mem_lr_n || !mem_ce_n;
            if (bus_act)
                check("bus_overlap", mem_lr_n | mem_ce_n, 1);
            if (!bist_mode) begin
                if (bus_act)
                    check("bus_gap", prev_act, 0);
                prev_act = bus_act;
            end
        end
    end

    // Presents one command from a negedge, holds it until accepted, returns at the next negedge.
    task automatic send(input logic w, input logic [3:0] a, input logic [7:0] d, output int hs);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        hs = -1;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (cmd_ready) begin
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        if (hs < 0) begin
            check("cmd_accept_timeout", cmd_ready, 1);
        end else if (w) begin
            ref_mem[a] = d;
        end else begin
            e.data = ref_mem[a];
            e.due  = cyc + 3;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic check_idle_bus(input string tag);
        check({tag, "_ce_n"}, mem_ce_n, 1);
        check({tag, "_lr_n"}, mem_lr_n, 1);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
    endtask

`ifdef MEM_BIST_EN
    // Pulses bist_start at the current negedge and follows the run to its done pulse.
    task automatic run_bist(input int exp_len, input logic exp_pass, input logic [3:0] exp_fail);
        int s;
        int done_cyc;
        logic [7:0] v;
        bist_mode  = 1'b1;
        bist_start = 1'b1;
        s = cyc;
        @(negedge clk);
        bist_start = 1'b0;
        check("bist_busy_start", bist_busy, 1);
        check("bist_pass_cleared", bist_pass, 0);
        check("bist_fail_cleared", bist_fail_addr, 0);
        done_cyc = -1;
        for (int i = 0; i < 300; i++) begin
            check("bist_cmd_ready", cmd_ready, 0);
            if (bist_done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        check("bist_done_cycle", done_cyc, s + exp_len);
        check("bist_pass", bist_pass, exp_pass);
        check("bist_fail_addr", bist_fail_addr, exp_fail);
        check("bist_busy_at_done", bist_busy, 0);
        if (exp_pass) begin
            for (int a = 0; a < 16; a++) begin
                v = ~(8'hA5 ^ 8'(a));
                check("bist_mem_final", mem[a], v);
            end
        end
        @(negedge clk);
        check("bist_done_pulse", bist_done, 0);
        check("bist_pass_sticky", bist_pass, exp_pass);
        bist_mode = 1'b0;
    endtask
`endif

    initial begin
        int hs, prev_hs, s, gap;
        logic pw, w;
        logic [7:0] v;

        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        bist_start = 1'b0;
        for (int a = 0; a < 16; a++) begin
            v = 8'($urandom);
            mem[a] = v;
            ref_mem[a] = v;
        end
        repeat (3) @(negedge clk);
        check_idle_bus("reset");
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_bist", {bist_busy, bist_done, bist_pass, bist_fail_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed write then read of address 5.
        send(1'b1, 4'd5, 8'h3C, hs);
        cmd_valid = 1'b0;
        check("wr_lr_n", mem_lr_n, 0);
        check("wr_addr", mem_addr, 5);
        check("wr_wdata", mem_wdata, 8'h3C);
        check("wr_ce_n", mem_ce_n, 1);
        @(negedge clk);
        check_idle_bus("after_wr");
        send(1'b0, 4'd5, 8'h00, hs);
        cmd_valid = 1'b0;
        check("rd_ce_n", mem_ce_n, 0);
        check("rd_lr_n", mem_lr_n, 1);
        check("rd_addr", mem_addr, 5);
        @(negedge clk);
        check_idle_bus("rdw");
        check("rdw_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("rsp_c3_valid", rsp_valid, 1);
        check("rsp_c3_ready", cmd_ready, 1);
        @(negedge clk);
        check("rsp_one_cycle", rsp_valid, 0);
        check("rsp_hold", rsp_rdata, 8'h3C);

        // cmd_valid held high with alternating write/read commands.
        prev_hs = -1; pw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w = (i % 2 == 0);
            send(w, 4'(i + 8), 8'($urandom), hs);
            if (prev_hs >= 0)
                check("b2b_spacing", hs - prev_hs, pw ? 2 : 3);
            prev_hs = hs; pw = w;
        end
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the RDW cycle drops the response.
        send(1'b0, 4'd7, 8'h00, hs);
        cmd_valid = 1'b0;
        @(negedge clk);
        void'(sb.pop_back());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstrdw_rsp_valid", rsp_valid, 0);
        check("rstrdw_rsp_rdata", rsp_rdata, 0);
        check("rstrdw_cmd_ready", cmd_ready, 1);
        check_idle_bus("rstrdw");
        @(negedge clk);
        check("rstrdw_no_rsp", rsp_valid, 0);

        // Reset coinciding with a write bus cycle: the write still lands.
        send(1'b1, 4'd2, 8'h5A, hs);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_bus("rstwr");
        check("rstwr_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        send(1'b0, 4'd2, 8'h00, hs);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);

`ifdef MEM_BIST_EN
        // bist_start and cmd_valid in the same IDLE cycle: BIST wins, command waits.
        for (int a = 0; a < 16; a++)
            ref_mem[a] = ~(8'hA5 ^ 8'(a));
        s = cyc;
        fork
            send(1'b1, 4'd3, 8'h77, hs);
            run_bist(97, 1'b1, 4'd0);
        join
        cmd_valid = 1'b0;
        check("bist_cmd_accept_cycle", hs, s + 98);
        repeat (2) @(negedge clk);

        // Stuck-at-0 on bit 2 of address 9 fails during pass 0.
        fault_en = 1'b1;
        for (int a = 0; a < 16; a++)
            ref_mem[a] = 8'hA5 ^ 8'(a);
        ref_mem[9] = (8'hA5 ^ 8'h09) & 8'hFB;
        run_bist(37, 1'b0, 4'd9);
        fault_en = 1'b0;
        @(negedge clk);
`else
        // Without BIST, bist_start is ignored and the command is accepted at once.
        bist_start = 1'b1;
        s = cyc;
        send(1'b1, 4'd3, 8'h77, hs);
        bist_start = 1'b0;
        cmd_valid  = 1'b0;
        check("nobist_accept_cycle", hs, s);
        for (int i = 0; i < 3; i++) begin
            check("nobist_outputs", {bist_busy, bist_done, bist_pass, bist_fail_addr}, 0);
            @(negedge clk);
        end
`endif

        // Randomized traffic with random gaps.
        prev_hs = -1; pw = 1'b0; gap = 1;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom);
            send(w, 4'($urandom), 8'($urandom), hs);
            if (prev_hs >= 0 && gap == 0)
                check("rand_spacing", hs - prev_hs, pw ? 2 : 3);
            prev_hs = hs; pw = w;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                cmd_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_seq_master.md
Name: mem_seq_master

Overview:
- Initiator for the 16-byte DFF memory bus (addr, active-low chip enable, active-low load, write data in, registered read data out).
- Turns a host valid/ready command port into correctly timed memory bus cycles and returns read data on a one-cycle response strobe.
- Optionally includes a built-in march test engine that fills, reads back and checks the whole array.
- Sits between the host-side logic and the memory.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- DEPTH, 16, number of words covered by BIST; must equal 2**ADDR_W.
- SEED, 8'hA5, BIST base pattern.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  host command ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_rdata  out  DATA_W  read data; held until next response.
- mem_addr  out  ADDR_W  memory address.
- mem_ce_n  out  1  memory chip enable (read), active low.
- mem_lr_n  out  1  memory load/write, active low.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory registered read data.
- bist_start  in  1  start BIST (single-cycle pulse, sampled in IDLE).
- bist_busy  out  1  BIST running.
- bist_done  out  1  one-cycle BIST completion pulse.
- bist_pass  out  1  BIST result; sticky.
- bist_fail_addr  out  ADDR_W  first failing address.

Behaviour:
- Memory contract: write when mem_lr_n=0 at an edge (mem_ce_n ignored). Read when mem_lr_n=1 and mem_ce_n=0 at edge E; mem_rdata is valid after E and is captured at E+1.
- All mem_* outputs are registered.
- Idle bus: mem_ce_n=1, mem_lr_n=1, mem_addr=0, mem_wdata=0.
- Reset values: idle bus, rsp_valid=0, rsp_rdata=0, all bist_* outputs=0, state IDLE.
- cmd_ready = (state==IDLE) && !bist_start. This is combinational.
- States: IDLE, WR, RD, RDW, plus B_WR, B_RD, B_RDW, B_DONE when BIST is compiled in.
- Write accepted at edge E0: WR drives lr_n=0, addr and wdata during cycle C1. The memory writes at E1, then state returns to IDLE. Maximum write rate is 1 per 2 cycles. No response is generated.
- Read accepted at E0:
  - RD drives ce_n=0 and addr in C1.
  - RDW drives the idle bus in C2; rsp_rdata <= mem_rdata at E2.
  - rsp_valid=1 for exactly C3; state is IDLE in C3, so cmd_ready may be 1 there.
  - Maximum read rate is 1 per 3 cycles.
- cmd_* fields are sampled only at the handshake edge.
- bist_start in IDLE has priority over cmd_valid in the same cycle. bist_start is ignored in any other state.
- Reset mid-operation returns to IDLE at that edge; no rsp_valid follows. A memory write whose bus cycle coincides with the reset edge still lands, because the memory has no reset.

Optional Feature:
- Macro: MEM_BIST_EN.
- With MEM_BIST_EN:
  - bist_start clears bist_pass and bist_fail_addr, and sets bist_busy from the next cycle.
  - Pass P0 pattern: d(a) = SEED ^ a (a zero-extended). Pass P1 pattern: d(a) = ~(SEED ^ a).
  - Each pass:
    - B_WR writes addresses 0..DEPTH-1 back-to-back, 1 cycle each.
    - For each address 0..DEPTH-1: B_RD issues the read, then B_RDW compares mem_rdata to d(a) at the capture edge.
  - First mismatch: bist_fail_addr=a, bist_pass=0, go to B_DONE immediately.
  - Both passes clean: bist_pass=1.
  - B_DONE: bist_done=1 for one cycle, bist_busy=0, then IDLE.
  - Total clean run is 2*(DEPTH+2*DEPTH) = 96 cycles, then 1 cycle in B_DONE.
  - cmd_ready=0 throughout.
  - Reset aborts the run and clears all bist_* outputs.
- Without MEM_BIST_EN:
  - No BIST states or logic.
  - bist_busy, bist_done, bist_pass and bist_fail_addr are tied 0.
  - bist_start is ignored; cmd_ready = (state==IDLE).

Test Plan:
- Write 0x3C to addr 5, then read addr 5 → bus shows lr_n=0/addr=5/wdata=0x3C for one cycle; rsp_valid in the 3rd cycle after read acceptance with rsp_rdata=0x3C.
- cmd_valid held high with alternating write/read commands → handshakes spaced 2 cycles after a write and 3 cycles after a read; no bus cycle overlaps; bus idle between them.
- Assert rst during the RDW cycle of a read → no rsp_valid; idle bus and cmd_ready=1 on the next cycle.
- MEM_BIST_EN with behavioural memory model → bist_done after 97 cycles, bist_pass=1; memory ends with ~(0xA5^a) at each address.
- MEM_BIST_EN with addr 9 bit 2 stuck-at-0 → bist_pass=0, bist_fail_addr=9, bist_done pulse.
- bist_start and cmd_valid asserted in the same IDLE cycle → BIST starts; command not accepted (cmd_ready=0) until bist_done. Without MEM_BIST_EN, the same stimulus → command accepted and bist_* stays 0.
